osd_spi_master: RTL and testbench
=================================

// Module: osd_spi_master
// PURPOSE
//  Local SPI master that drives the OSD overlay's SPI port (sck/ss/sdi).
//  Sequences OSD commands from core logic: enable, disable, and 256-byte line writes.
//  Line-write payload is pulled byte by byte from a requester-side source over a req/valid fetch port.
//  Sits between the core's status/menu logic and the OSD; all logic runs in the pixel clock domain.
// PARAMETERS
//  CLK_DIV  4  clk cycles per SCK half-period; legal range >=1
//  SS_GAP   2  SCK half-periods that ss stays high between transactions; legal range >=1
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  reset      in   1  synchronous reset, active high
//  req_valid  in   1  command request valid
//  req_ready  out  1  request accepted on clk where req_valid && req_ready
//  req_op     in   2  0=disable 1=enable 2=write line 3=nop
//  req_line   in   3  line index for op 2
//  dat_req    out  1  payload byte request; held until dat_valid
//  dat_addr   out  8  byte index within the line, 0..255
//  dat_valid  in   1  payload byte valid; sampled only while dat_req=1
//  dat_byte   in   8  payload byte
//  busy       out  1  1 whenever state != IDLE
//  done       out  1  one-cycle pulse at transaction end
//  spi_sck    out  1  SPI clock, idle low
//  spi_ss     out  1  slave select, active low, idle high
//  spi_sdi    out  1  serial data to OSD, MSB first
// BEHAVIOUR
//  Reset values: spi_ss=1, spi_sck=0, spi_sdi=0, dat_req=0, dat_addr=0, done=0, busy=0.
//  - req_ready = (state==IDLE) && !reset.
//  Reset mid-transfer: takes effect the next clk and aborts immediately; the OSD discards a partial frame on ss high.
//  Command byte:
//  - op0 -> 0x40, op1 -> 0x41, op2 -> {5'b00100, req_line}.
//  - op and line are latched at accept.
//  Op 3 (nop): accepted, no SPI activity, done pulses on the clk after accept.
//  States: IDLE -> SHIFT -> [FETCH <-> SHIFT]* -> TAIL -> GAP -> IDLE.
//  SHIFT (per bit, MSB first):
//  - sdi = current bit, sck=0 for CLK_DIV clks; then sck=1 for CLK_DIV clks.
//  - sdi changes only while sck=0, so the OSD samples a stable bit on the rising edge.
//  Transaction start: accept at clk T; ss=0, sdi=bit7 and sck=0 from T+1; first sck rise at T+1+CLK_DIV.
//  Op 2 payload:
//  - After the last command bit, enter FETCH with dat_req=1 and dat_addr=0.
//  - The byte is captured on the clk with dat_req && dat_valid; dat_req drops the next clk; SHIFT resumes.
//  - Repeat for addr 1..255. During FETCH: sck=0, ss=0, sdi holds its last value.
//  - Bytes are sent in strict address order, with no prefetch.
//  Ops 0/1 go from SHIFT straight to TAIL after 8 bits.
//  TAIL: sck=0, sdi=0, ss=0 for CLK_DIV clks.
//  GAP: ss=1 for SS_GAP*CLK_DIV clks; then IDLE with done=1 for that one clk (req_ready also 1).
//  Counters:
//  - bit counter is 3 bits; byte counter is 9 bits (0..256, terminal at 256); dividers are sized by $clog2.
//  - No counter wraps within a transaction.
//  Enable/disable total, with defaults: ss low T+1..T+68; ss high from T+69; done at T+77.
//  dat_valid while dat_req=0 is ignored. req_valid outside IDLE is ignored (no queuing).
// TESTING
//  1 op1, defaults -> slave model decodes 0x41; ss low exactly 68 clks; done at accept+77; osd_enable=1.
//  2 op2 line 5, zero-wait source dat_byte=dat_addr^8'hA5 -> bytes 0x25 then 256 payload bytes.
//    Check: dat_addr 0..255 in order; OSD model buffer[0x500+i]==i^0xA5.
//  3 as test 2, source wait randomised 0..7 clks -> identical stream; sck=0 and ss=0 throughout stalls.
//    Check: no sck edge while dat_req=1.
//  4 reset during payload byte 100 -> next clk: ss=1, sck=0, dat_req=0, busy=0.
//    Then op0 after release -> clean 0x40 frame.
//  5 req_valid held with op1, then op0 back-to-back -> second accept on the done clk.
//    Check: ss high >= SS_GAP*CLK_DIV clks between frames.
//  6 op3 -> ss never falls; done one clk after accept; CLK_DIV=1 run of test 2 also passes.

Source files
------------

// File: rtl/osd_spi_master.sv
// SPI master for the OSD overlay: enable/disable commands and 256-byte line writes,
// with payload fetched one byte at a time over a req/valid port.
//
// state | meaning
// IDLE  | waiting for a command; ss high
// SHIFT | clocking out the current byte, MSB first
// FETCH | sck parked low, waiting for the next payload byte
// TAIL  | ss still low, sdi low, one half-period after the last bit
// GAP   | ss high for SS_GAP half-periods before the next command
module osd_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [2:0] req_line,
    output logic       dat_req,
    output logic [7:0] dat_addr,
    input  logic       dat_valid,
    input  logic [7:0] dat_byte,
    output logic       busy,
    output logic       done,
    output logic       spi_sck,
    output logic       spi_ss,
    output logic       spi_sdi
);

    localparam int GAP_CLKS = SS_GAP * CLK_DIV;
    // One timer serves both the half-period and the ss gap; the gap is never shorter.
    localparam int TMR_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [TMR_W-1:0] DIV_LOAD = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CLKS - 1);

    localparam logic [1:0] OP_LINE = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    typedef enum logic [2:0] {IDLE, SHIFT, FETCH, TAIL, GAP} state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [2:0]       bit_cnt;
    logic [8:0]       byte_cnt;
    logic [7:0]       shreg;
    logic             is_line;
    logic [7:0]       cmd;

    always_comb begin
        cmd = 8'h40;
        case (req_op)
            2'd1:    cmd = 8'h41;
            OP_LINE: cmd = {5'b00100, req_line};
            default: cmd = 8'h40;
        endcase
    end

    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tmr      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            is_line  <= 1'b0;
            dat_req  <= 1'b0;
            dat_addr <= '0;
            done     <= 1'b0;
            spi_sck  <= 1'b0;
            spi_ss   <= 1'b1;
            spi_sdi  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_op == OP_NOP) begin
                            done <= 1'b1;
                        end else begin
                            shreg    <= cmd;
                            spi_sdi  <= cmd[7];
                            spi_ss   <= 1'b0;
                            spi_sck  <= 1'b0;
                            tmr      <= DIV_LOAD;
                            bit_cnt  <= 3'd7;
                            byte_cnt <= '0;
                            is_line  <= (req_op == OP_LINE);
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end else if (!spi_sck) begin
                        spi_sck <= 1'b1;
                        tmr     <= DIV_LOAD;
                    end else begin
                        spi_sck <= 1'b0;
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                            spi_sdi <= shreg[6];
                            tmr     <= DIV_LOAD;
                        end else if (is_line && byte_cnt != 9'd256) begin
                            state    <= FETCH;
                            dat_req  <= 1'b1;
                            dat_addr <= byte_cnt[7:0];
                        end else begin
                            state   <= TAIL;
                            spi_sdi <= 1'b0;
                            tmr     <= DIV_LOAD;
                        end
                    end
                end
                FETCH: begin
                    if (dat_valid) begin
                        shreg    <= dat_byte;
                        spi_sdi  <= dat_byte[7];
                        dat_req  <= 1'b0;
                        byte_cnt <= byte_cnt + 9'd1;
                        bit_cnt  <= 3'd7;
                        tmr      <= DIV_LOAD;
                        state    <= SHIFT;
                    end
                end
                TAIL: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end else begin
                        state  <= GAP;
                        spi_ss <= 1'b1;
                        tmr    <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_spi_master.sv
// Directed bench for osd_spi_master: instance 0 uses default timing, instance 1 runs CLK_DIV=1.
// A shared OSD slave model and payload source observe both instances on the falling clock edge.
module tb_osd_spi_master;

    logic       clk = 1'b0;
    logic       reset     [2] = '{1'b1, 1'b1};
    logic       req_valid [2] = '{1'b0, 1'b0};
    logic [1:0] req_op    [2] = '{2'd3, 2'd3};
    logic [2:0] req_line  [2] = '{3'd0, 3'd0};
    logic       dat_valid [2] = '{1'b0, 1'b0};
    logic [7:0] dat_byte  [2] = '{8'h00, 8'h00};
    logic       req_ready [2];
    logic       dat_req   [2];
    logic [7:0] dat_addr  [2];
    logic       busy      [2];
    logic       done      [2];
    logic       sck       [2];
    logic       ss        [2];
    logic       sdi       [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    osd_spi_master u_dut0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_line(req_line[0]), .dat_req(dat_req[0]), .dat_addr(dat_addr[0]),
        .dat_valid(dat_valid[0]), .dat_byte(dat_byte[0]), .busy(busy[0]), .done(done[0]),
        .spi_sck(sck[0]), .spi_ss(ss[0]), .spi_sdi(sdi[0])
    );

    osd_spi_master #(.CLK_DIV(1), .SS_GAP(2)) u_dut1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_line(req_line[1]), .dat_req(dat_req[1]), .dat_addr(dat_addr[1]),
        .dat_valid(dat_valid[1]), .dat_byte(dat_byte[1]), .busy(busy[1]), .done(done[1]),
        .spi_sck(sck[1]), .spi_ss(ss[1]), .spi_sdi(sdi[1])
    );

    // Slave model / source state, written only by the monitor process.
    logic       prev_sck    [2] = '{1'b0, 1'b0};
    logic       prev_ss     [2] = '{1'b1, 1'b1};
    logic [7:0] sr          [2] = '{8'h00, 8'h00};
    int         bitn        [2] = '{0, 0};
    logic [7:0] fr          [2][0:299];
    int         fr_len      [2] = '{0, 0};
    logic [7:0] osd_buf     [2][0:2047];
    logic       osd_en      [2] = '{1'b0, 1'b0};
    int         commits     [2] = '{0, 0};
    int         ss_fall_cyc [2] = '{0, 0};
    int         ss_rise_cyc [2] = '{0, 0};
    int         last_gap    [2] = '{0, 0};
    int         ss_falls    [2] = '{0, 0};
    int         acc_cyc     [2] = '{0, 0};
    int         stall_err   [2] = '{0, 0};
    int         order_err   [2] = '{0, 0};
    int         fetches     [2] = '{0, 0};
    logic [7:0] exp_addr    [2] = '{8'h00, 8'h00};
    int         wait_cnt    [2] = '{0, 0};
    bit         rnd_mode    [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (req_valid[k] && req_ready[k]) acc_cyc[k] = cyc;
            if (!ss[k] && prev_ss[k]) begin
                ss_fall_cyc[k] = cyc;
                last_gap[k]    = cyc - ss_rise_cyc[k];
                ss_falls[k]++;
                bitn[k]   = 0;
                fr_len[k] = 0;
            end
            if (!ss[k] && sck[k] && !prev_sck[k]) begin
                sr[k] = {sr[k][6:0], sdi[k]};
                bitn[k]++;
                if (bitn[k] == 8) begin
                    if (fr_len[k] < 300) fr[k][fr_len[k]] = sr[k];
                    fr_len[k]++;
                    bitn[k] = 0;
                end
            end
            if (ss[k] && !prev_ss[k]) begin
                ss_rise_cyc[k] = cyc;
                if (bitn[k] == 0) begin
                    if (fr_len[k] == 1 && fr[k][0] == 8'h40) begin
                        osd_en[k] = 1'b0;
                        commits[k]++;
                    end else if (fr_len[k] == 1 && fr[k][0] == 8'h41) begin
                        osd_en[k] = 1'b1;
                        commits[k]++;
                    end else if (fr_len[k] == 257 && fr[k][0][7:3] == 5'b00100) begin
                        for (int i = 0; i < 256; i++)
                            osd_buf[k][int'(fr[k][0][2:0]) * 256 + i] = fr[k][i + 1];
                        commits[k]++;
                    end
                end
            end
            if (dat_req[k] && (sck[k] !== 1'b0 || ss[k] !== 1'b0)) stall_err[k]++;
            prev_sck[k] = sck[k];
            prev_ss[k]  = ss[k];

            if (dat_req[k]) begin
                if (!dat_valid[k]) begin
                    if (wait_cnt[k] == 0) begin
                        dat_valid[k] = 1'b1;
                        dat_byte[k]  = dat_addr[k] ^ 8'hA5;
                        if (dat_addr[k] !== exp_addr[k]) order_err[k]++;
                        exp_addr[k]++;
                        fetches[k]++;
                    end else begin
                        wait_cnt[k]--;
                    end
                end
            end else begin
                dat_valid[k] = 1'b0;
                dat_byte[k]  = 8'h00;
                wait_cnt[k]  = rnd_mode[k] ? int'($urandom_range(0, 7)) : 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int k, input logic [1:0] op, input logic [2:0] line,
                         input bit hold, output int t);
        bit got = 1'b0;
        t = -1;
        @(posedge clk); #1;
        req_valid[k] = 1'b1;
        req_op[k]    = op;
        req_line[k]  = line;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                got = 1'b1;
                t   = cyc;
            end
        end
        check("accept_seen", 32'(got), 32'd1);
        if (!hold) begin
            @(posedge clk); #1;
            req_valid[k] = 1'b0;
        end
    endtask

    task automatic wait_done(input int k, input int bound, output int t);
        bit got = 1'b0;
        t = -1;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (done[k]) begin
                got = 1'b1;
                t   = cyc;
            end
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int t, td, d1, base_c, base_f, base_o, bad;

        // Reset and idle values
        repeat (4) @(negedge clk);
        check("rst_ready", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        @(negedge clk);
        check("rst_ss",    32'(ss[0]),       32'd1);
        check("rst_sck",   32'(sck[0]),      32'd0);
        check("rst_sdi",   32'(sdi[0]),      32'd0);
        check("rst_dreq",  32'(dat_req[0]),  32'd0);
        check("rst_daddr", 32'(dat_addr[0]), 32'd0);
        check("rst_done",  32'(done[0]),     32'd0);
        check("rst_busy",  32'(busy[0]),     32'd0);
        check("idle_ready", 32'(req_ready[0]), 32'd1);

        // 1: enable, default timing
        issue(0, 2'd1, 3'd0, 1'b0, t);
        wait_done(0, 200, td);
        check("t1_cmd",     32'(fr[0][0]),    32'h41);
        check("t1_len",     32'(fr_len[0]),   32'd1);
        check("t1_ss_fall", 32'(ss_fall_cyc[0]), 32'(t + 1));
        check("t1_ss_rise", 32'(ss_rise_cyc[0]), 32'(t + 69));
        check("t1_done",    32'(td),          32'(t + 77));
        check("t1_osd_en",  32'(osd_en[0]),   32'd1);

        // 2: line 5 write, zero-wait source
        base_c = commits[0];
        base_f = fetches[0];
        issue(0, 2'd2, 3'd5, 1'b0, t);
        wait_done(0, 20000, td);
        check("t2_len",    32'(fr_len[0]),  32'd257);
        check("t2_cmd",    32'(fr[0][0]),   32'h25);
        check("t2_fetch",  32'(fetches[0] - base_f), 32'd256);
        check("t2_order",  32'(order_err[0]), 32'd0);
        check("t2_commit", 32'(commits[0] - base_c), 32'd1);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (osd_buf[0][1280 + i] !== (i[7:0] ^ 8'hA5)) bad++;
        check("t2_buf", 32'(bad), 32'd0);

        // 3: same write with random source wait
        rnd_mode[0] = 1'b1;
        issue(0, 2'd2, 3'd5, 1'b0, t);
        wait_done(0, 20000, td);
        check("t3_len",   32'(fr_len[0]),    32'd257);
        check("t3_cmd",   32'(fr[0][0]),     32'h25);
        check("t3_order", 32'(order_err[0]), 32'd0);
        check("t3_stall", 32'(stall_err[0]), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (fr[0][i + 1] !== (i[7:0] ^ 8'hA5)) bad++;
        check("t3_stream", 32'(bad), 32'd0);

        // 4: reset during payload byte 100, then a clean disable
        rnd_mode[0] = 1'b0;
        base_c = commits[0];
        issue(0, 2'd2, 3'd2, 1'b0, t);
        bad = 1;
        for (int i = 0; i < 20000 && bad != 0; i++) begin
            @(negedge clk);
            if (dat_req[0] && dat_addr[0] == 8'd100) bad = 0;
        end
        check("t4_reach100", 32'(bad), 32'd0);
        @(posedge clk); #1;
        reset[0] = 1'b1;
        @(negedge clk);
        check("t4_ready_rst", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        check("t4_ss",   32'(ss[0]),      32'd1);
        check("t4_sck",  32'(sck[0]),     32'd0);
        check("t4_dreq", 32'(dat_req[0]), 32'd0);
        check("t4_busy", 32'(busy[0]),    32'd0);
        @(posedge clk); #1;
        reset[0] = 1'b0;
        @(negedge clk);
        check("t4_discard", 32'(commits[0] - base_c), 32'd0);
        issue(0, 2'd0, 3'd0, 1'b0, t);
        wait_done(0, 200, td);
        check("t4_cmd",    32'(fr[0][0]),  32'h40);
        check("t4_len",    32'(fr_len[0]), 32'd1);
        check("t4_osd_en", 32'(osd_en[0]), 32'd0);
        check("t4_done",   32'(td),        32'(t + 77));

        // 5: back-to-back enable then disable with req_valid held
        base_c = commits[0];
        issue(0, 2'd1, 3'd0, 1'b1, t);
        @(posedge clk); #1;
        req_op[0] = 2'd0;
        wait_done(0, 200, d1);
        check("t5_done1", 32'(d1), 32'(t + 77));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_done(0, 200, td);
        check("t5_acc2",   32'(acc_cyc[0]), 32'(d1));
        check("t5_gap",    32'(last_gap[0] >= 8), 32'd1);
        check("t5_cmd2",   32'(fr[0][0]),   32'h40);
        check("t5_commit", 32'(commits[0] - base_c), 32'd2);
        check("t5_osd_en", 32'(osd_en[0]),  32'd0);

        // 6: nop, then CLK_DIV=1 instance
        base_f = ss_falls[0];
        issue(0, 2'd3, 3'd0, 1'b0, t);
        wait_done(0, 20, td);
        check("t6_nop_done",  32'(td),        32'(t + 1));
        check("t6_nop_ss",    32'(ss_falls[0] - base_f), 32'd0);
        check("t6_nop_busy",  32'(busy[0]),   32'd0);
        check("t6_nop_ready", 32'(req_ready[0]), 32'd1);

        issue(1, 2'd1, 3'd0, 1'b0, t);
        wait_done(1, 100, td);
        check("d1_cmd",     32'(fr[1][0]),       32'h41);
        check("d1_ss_fall", 32'(ss_fall_cyc[1]), 32'(t + 1));
        check("d1_ss_rise", 32'(ss_rise_cyc[1]), 32'(t + 18));
        check("d1_done",    32'(td),             32'(t + 20));

        rnd_mode[1] = 1'b1;
        issue(1, 2'd2, 3'd3, 1'b0, t);
        wait_done(1, 20000, td);
        check("d1_len",   32'(fr_len[1]),    32'd257);
        check("d1_lcmd",  32'(fr[1][0]),     32'h23);
        check("d1_order", 32'(order_err[1]), 32'd0);
        check("d1_stall", 32'(stall_err[1]), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (osd_buf[1][768 + i] !== (i[7:0] ^ 8'hA5)) bad++;
        check("d1_buf", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
